// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FULL  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Misaligned or beyond the end of instruction memory.
  function automatic logic pc_is_bad(input logic [ADDR_W-1:0] pc,
                                     input logic [ADDR_W-1:0] limit);
    return (pc[1:0] != 2'b00) || (pc >= limit);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: head {pc, instr} with valid/ready.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
();
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
  modport slave  (input instr_valid, input instr, input instr_pc, output instr_ready);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a registered head that holds its
// last value while empty.
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] kept_c;
  logic             valid_q, valid_d;
  logic             pop_ok_c;
  fetch_entry_t     head_q, head_d;

  // Next head: oldest surviving entry, else the word being written now.
  always_comb begin
    pop_ok_c = pop_i && (count_q != '0);
    kept_c   = count_q - CNT_W'(pop_ok_c);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok_c);
    count_d  = kept_c + CNT_W'(push_i);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    if (kept_c != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_i) begin
      head_d = data_i;
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      head_d   = head_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, prefetch into a small FIFO, branch
// redirect and sticky fetch-fault handling.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MEM_WORDS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [ADDR_W-1:0]   pc_addr_o,
  input  logic [DATA_W-1:0]   instr_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  instr_fetch_unit_if.master  dec_if,
  output logic                fetch_err_o
);

  localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS * INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count;
  logic              bad_pc_c, pop_c, push_c, full_c;
  fetch_entry_t      wr_entry, head;

  assign bad_pc_c = pc_is_bad(fetch_pc_q, MEM_LIMIT);
  assign pop_c    = dec_if.instr_valid && dec_if.instr_ready;
  assign full_c   = (count == CNT_W'(DEPTH));
  assign push_c   = (state_q == ST_RUN) && (!full_c || pop_c) && !redirect_i && !bad_pc_c;
  assign wr_entry = '{pc: fetch_pc_q, instr: instr_i};

  // Next state / next PC; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc_i;
    end else begin
      if (push_c) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
      end
      unique case (state_q)
        ST_RUN: begin
          if (bad_pc_c)              state_d = ST_FAULT;
          else if (full_c && !pop_c) state_d = ST_FULL;
        end
        ST_FULL: begin
          if (bad_pc_c)   state_d = ST_FAULT;
          else if (pop_c) state_d = ST_RUN;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RUN;
      endcase
    end
    err_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      err_q      <= err_d;
    end
  end

  instr_fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (redirect_i),
    .data_i  (wr_entry),
    .count_o (count),
    .valid_o (dec_if.instr_valid),
    .head_o  (head)
  );

  assign dec_if.instr    = head.instr;
  assign dec_if.instr_pc = head.pc;
  assign pc_addr_o       = fetch_pc_q;
  assign fetch_err_o     = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: queue-based reference model compared
// every cycle, plus literal expectations for each scenario.
module tb_instr_fetch_unit;

  localparam int M_RUN   = 0;
  localparam int M_FULL  = 1;
  localparam int M_FAULT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        fetch_err_o;
  logic [31:0] imem [32];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  ent_t        mq[$];
  logic [31:0] m_pc  = '0;
  logic [31:0] m_hpc = '0;
  logic [31:0] m_hin = '0;
  int          m_mode = M_RUN;

  instr_fetch_unit_if dec_if ();

  instr_fetch_unit #(.DEPTH(4), .MEM_WORDS(32), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec_if        (dec_if),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  assign instr_i = (pc_addr_o < 32'd128) ? imem[pc_addr_o[6:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] mem_model(input logic [31:0] pc);
    return (pc < 32'd128) ? 32'h100 + pc / 4 : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Reference model: FIFO as a queue, applied at each rising edge.
  always @(posedge clk_i or negedge rst_i) begin : model
    bit   pop, push, bad, was_full;
    ent_t e;
    if (!rst_i) begin
      mq.delete();
      m_pc   = '0;
      m_hpc  = '0;
      m_hin  = '0;
      m_mode = M_RUN;
    end else begin
      pop = (mq.size() != 0) && dec_if.instr_ready;
      bad = (m_pc % 4 != 0) || (m_pc >= 32'd128);
      if (redirect_i) begin
        mq.delete();
        m_pc   = redirect_pc_i;
        m_mode = M_RUN;
      end else begin
        was_full = (mq.size() == 4);
        push = (m_mode == M_RUN) && (!was_full || pop) && !bad;
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.pc    = m_pc;
          e.instr = mem_model(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 4;
        end
        if (m_mode != M_FAULT) begin
          if (bad) m_mode = M_FAULT;
          else if (m_mode == M_RUN && was_full && !pop) m_mode = M_FULL;
          else if (m_mode == M_FULL && pop) m_mode = M_RUN;
        end
      end
      if (mq.size() != 0) begin
        m_hpc = mq[0].pc;
        m_hin = mq[0].instr;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("m_pc_addr", pc_addr_o, m_pc);
      chk("m_valid", 32'(dec_if.instr_valid), 32'(mq.size() != 0));
      chk("m_instr", dec_if.instr, m_hin);
      chk("m_instr_pc", dec_if.instr_pc, m_hpc);
      chk("m_err", 32'(fetch_err_o), 32'(m_mode == M_FAULT));
    end
  end

  // Reset edges placed mid-phase, away from clock edges and compare points.
  task automatic do_reset();
    #2 rst_i = 1'b0;
    tick(2);
    #2 rst_i = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick(1);
    redirect_i    = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) imem[k] = 32'h100 + 32'(k);
    dec_if.instr_ready = 1'b1;
    #1 rst_i = 1'b0;
    tick(1);
    chk_en = 1'b1;
    chk("rst_valid", 32'(dec_if.instr_valid), 32'h0);
    chk("rst_err", 32'(fetch_err_o), 32'h0);
    chk("rst_pc_addr", pc_addr_o, 32'h0);
    chk("rst_instr", dec_if.instr, 32'h0);
    #2 rst_i = 1'b1;

    // 1: streaming with ready=1
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t1_valid", 32'(dec_if.instr_valid), 32'h1);
      chk("t1_instr", dec_if.instr, 32'h100 + 32'(i));
      chk("t1_pc", dec_if.instr_pc, 32'(4 * i));
    end

    // 2: decode stall fills the FIFO, then drains one per cycle
    dec_if.instr_ready = 1'b0;
    do_reset();
    tick(10);
    chk("t2_pc_addr_held", pc_addr_o, 32'h10);
    chk("t2_head_pc", dec_if.instr_pc, 32'h0);
    dec_if.instr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("t2_seq_pc", dec_if.instr_pc, 32'(4 * i));
      chk("t2_seq_instr", dec_if.instr, 32'h100 + 32'(i));
    end

    // 3: redirect while full
    dec_if.instr_ready = 1'b0;
    tick(6);
    redirect_to(32'h40);
    chk("t3_flush_valid", 32'(dec_if.instr_valid), 32'h0);
    tick(1);
    chk("t3_valid", 32'(dec_if.instr_valid), 32'h1);
    chk("t3_pc", dec_if.instr_pc, 32'h40);
    chk("t3_instr", dec_if.instr, 32'h110);

    // 4: run off the end of memory, drain, then clear by redirect
    redirect_to(32'h78);
    tick(5);
    chk("t4_err", 32'(fetch_err_o), 32'h1);
    chk("t4_pc_addr", pc_addr_o, 32'h80);
    chk("t4_head_pc", dec_if.instr_pc, 32'h78);
    dec_if.instr_ready = 1'b1;
    tick(1);
    chk("t4_last_pc", dec_if.instr_pc, 32'h7C);
    chk("t4_last_instr", dec_if.instr, 32'h11F);
    tick(1);
    chk("t4_drained", 32'(dec_if.instr_valid), 32'h0);
    chk("t4_hold_pc", dec_if.instr_pc, 32'h7C);
    tick(2);
    chk("t4_no_push", 32'(dec_if.instr_valid), 32'h0);
    redirect_to(32'h0);
    chk("t4_err_clear", 32'(fetch_err_o), 32'h0);
    tick(1);
    chk("t4_restart", dec_if.instr, 32'h100);

    // 5: redirect to a misaligned PC
    redirect_to(32'h6);
    chk("t5_err_pre", 32'(fetch_err_o), 32'h0);
    tick(1);
    chk("t5_err", 32'(fetch_err_o), 32'h1);
    chk("t5_valid", 32'(dec_if.instr_valid), 32'h0);
    tick(2);
    chk("t5_valid_stays", 32'(dec_if.instr_valid), 32'h0);
    chk("t5_pc_addr", pc_addr_o, 32'h6);

    // 6: asynchronous reset with three entries buffered
    dec_if.instr_ready = 1'b0;
    redirect_to(32'h0);
    tick(3);
    chk("t6_pre_valid", 32'(dec_if.instr_valid), 32'h1);
    chk("t6_pre_pc_addr", pc_addr_o, 32'hC);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_valid", 32'(dec_if.instr_valid), 32'h0);
    chk("t6_err", 32'(fetch_err_o), 32'h0);
    chk("t6_pc_addr", pc_addr_o, 32'h0);
    chk("t6_instr", dec_if.instr, 32'h0);
    tick(1);
    #2 rst_i = 1'b1;
    dec_if.instr_ready = 1'b1;
    tick(2);
    chk("t6_after_pc", dec_if.instr_pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
